stack_unit: RTL

//   Hardware operand stack for the stack-machine datapath. It executes the

---
 rtl/stack_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module     : stack_unit
//  Description: Operand stack for the stack-machine datapath. It provides
//               push, pop and top-of-stack reads, a registered read port,
//               a combinational zero peek, and sticky overflow/underflow flags.
//  Revision   : 1.0 - initial release
// ============================================================================
module stack_unit #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stack_push,
    input  logic             stack_pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             zero,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] c_aw_one = AW'(1);
    localparam logic [CW-1:0] c_cw_one = CW'(1);
    localparam logic [CW-1:0] c_depth  = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_sp;
    logic [WIDTH-1:0] r_d_out;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW-1:0]    w_sp_lo;
    logic [AW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_idx;

    assign w_sp_lo   = r_sp[AW-1:0];
    // When full, the low bits of sp wrap to 0, so sp-1 still lands on the top slot.
    assign w_top_idx = w_sp_lo - c_aw_one;
    assign w_top     = r_mem[w_top_idx];
    assign w_full    = (r_sp == c_depth);
    assign w_empty   = (r_sp == '0);

    // Storage write port: replace-top, push onto empty, or plain push.
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = w_sp_lo;
        if (!rst) begin
            if (stack_push && stack_pop) begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_empty ? '0 : w_top_idx;
            end else if (stack_push && !stack_pop && !w_full) begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_sp_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_d_out     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (stack_push && stack_pop) begin
            if (!w_empty) begin
                r_d_out <= w_top;
            end else begin
                r_d_out     <= '0;
                r_underflow <= 1'b1;
                r_sp        <= c_cw_one;
            end
        end else if (stack_pop) begin
            if (!w_empty) begin
                r_d_out <= w_top;
                r_sp    <= r_sp - c_cw_one;
            end else begin
                r_d_out     <= '0;
                r_underflow <= 1'b1;
            end
        end else if (stack_push) begin
            if (!w_full) begin
                r_sp <= r_sp + c_cw_one;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (tos) begin
            if (!w_empty) begin
                r_d_out <= w_top;
            end else begin
                r_d_out     <= '0;
                r_underflow <= 1'b1;
            end
        end
    end

    assign d_out     = r_d_out;
    assign zero      = !w_empty && (w_top == '0);
    assign count     = r_sp;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
